// File: rtl/common_pkg.sv
// Shared timing constants, output bundle type and phase decoder for pet_timing.
// Build option: define MCU_SLOT_EN to give the MCU/SPI the bus for phases 0..15.
package common_pkg;

    localparam int unsigned SYS_CLOCK_MHZ = 64;
    localparam int unsigned CPU_CLOCK_MHZ = 1;
    localparam int unsigned PHASE_W       = 6;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PH_GRANT_MCU = 6'd1;   // MCU grant strobe
    localparam phase_t PH_MCU_END   = 6'd16;  // CPU regains the bus
    localparam phase_t PH_SR1       = 6'd31;  // shift register 1 load
    localparam phase_t PH_CPU_RISE  = 6'd32;  // PHI2 rises
    localparam phase_t PH_WR_FIRST  = 6'd56;  // write strobe window start
    localparam phase_t PH_WR_LAST   = 6'd62;  // write strobe window end
    localparam phase_t PH_SR2       = 6'd63;  // shift register 2 load

    localparam logic [0:0] GRANT_CPU = 1'b0;
    localparam logic [0:0] GRANT_MCU = 1'b1;

    typedef struct packed {
        logic       cpu_be;
        logic       cpu_clock;
        logic       cpu_wr_strobe;
        logic       load_sr1;
        logic       load_sr2;
        logic       clk8_en;
        logic       clk16_en;
        logic [0:0] grant;
        logic       grant_valid;
    } timing_t;

    // Decode every timing output from a phase value; phase 0 decodes to all zeros.
    function automatic timing_t decode_phase(phase_t p);
        timing_t t;
        t               = '0;
        t.clk16_en      = &p[1:0];
        t.clk8_en       = &p[2:0];
        t.cpu_clock     = (p >= PH_CPU_RISE);
        t.cpu_wr_strobe = (p >= PH_WR_FIRST) && (p <= PH_WR_LAST);
        t.load_sr1      = (p == PH_SR1);
        t.load_sr2      = (p == PH_SR2);
`ifdef MCU_SLOT_EN
        t.cpu_be        = (p >= PH_MCU_END);
        t.grant         = ((p >= PH_GRANT_MCU) && (p < PH_MCU_END)) ? GRANT_MCU : GRANT_CPU;
        t.grant_valid   = (p == PH_GRANT_MCU) || (p == PH_MCU_END);
`else
        t.cpu_be        = (p != '0);
        t.grant         = GRANT_CPU;
        t.grant_valid   = (p == PH_MCU_END);
`endif
        return t;
    endfunction

endpackage

// File: rtl/pet_timing.sv
// Free-running 1 us bus/video timing generator driven by a 64 MHz system clock.
// Build option: MCU_SLOT_EN enables the MCU bus slot (phases 0..15).
module pet_timing
    import common_pkg::*;
(
    input  logic       sys_clock_i,
    input  logic       reset_i,
    output logic       cpu_be_o,
    output logic       cpu_clock_o,
    output logic       cpu_wr_strobe_o,
    output logic       load_sr1_o,
    output logic       load_sr2_o,
    output logic       clk8_en_o,
    output logic       clk16_en_o,
    output logic [0:0] grant_o,
    output logic       grant_valid_o
);

    phase_t  p_q, p_d;
    timing_t out_q, out_d;

    // Next phase and its decode, so the output flops line up with the phase register.
    always_comb begin
        p_d   = p_q + phase_t'(1);
        out_d = decode_phase(p_d);
    end

    // Phase counter and registered outputs; reset parks everything at phase 0.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            p_q   <= '0;
            out_q <= '0;
        end else begin
            p_q   <= p_d;
            out_q <= out_d;
        end
    end

    assign cpu_be_o        = out_q.cpu_be;
    assign cpu_clock_o     = out_q.cpu_clock;
    assign cpu_wr_strobe_o = out_q.cpu_wr_strobe;
    assign load_sr1_o      = out_q.load_sr1;
    assign load_sr2_o      = out_q.load_sr2;
    assign clk8_en_o       = out_q.clk8_en;
    assign clk16_en_o      = out_q.clk16_en;
    assign grant_o         = out_q.grant;
    assign grant_valid_o   = out_q.grant_valid;

endmodule

// File: tb/tb_pet_timing.sv
// Self-checking bench for pet_timing: phase table, scoreboarded free run, reset corners.
`timescale 1ns/1ps
module tb_pet_timing;

    logic       sys_clock_i = 1'b0;
    logic       reset_i     = 1'b1;
    logic       cpu_be_o, cpu_clock_o, cpu_wr_strobe_o;
    logic       load_sr1_o, load_sr2_o, clk8_en_o, clk16_en_o;
    logic [0:0] grant_o;
    logic       grant_valid_o;

    int checks   = 0;
    int failures = 0;

    // Observed vector: [8]be [7]phi2 [6]wr [5]sr1 [4]sr2 [3]clk8 [2]clk16 [1]grant [0]grant_valid
    logic [8:0] obs;
    assign obs = {cpu_be_o, cpu_clock_o, cpu_wr_strobe_o, load_sr1_o, load_sr2_o,
                  clk8_en_o, clk16_en_o, grant_o, grant_valid_o};

    logic [8:0] sb_q[$];

    pet_timing dut (
        .sys_clock_i     (sys_clock_i),
        .reset_i         (reset_i),
        .cpu_be_o        (cpu_be_o),
        .cpu_clock_o     (cpu_clock_o),
        .cpu_wr_strobe_o (cpu_wr_strobe_o),
        .load_sr1_o      (load_sr1_o),
        .load_sr2_o      (load_sr2_o),
        .clk8_en_o       (clk8_en_o),
        .clk16_en_o      (clk16_en_o),
        .grant_o         (grant_o),
        .grant_valid_o   (grant_valid_o)
    );

    // 64 MHz: 15.625 ns period
    initial forever #7.8125 sys_clock_i = ~sys_clock_i;

    // Reference behaviour written from the phase ranges.
    function automatic logic [8:0] exp_out(int p);
        logic be, g, gv;
`ifdef MCU_SLOT_EN
        be = (p >= 16);
        g  = (p >= 1 && p <= 15);
        gv = (p == 1 || p == 16);
`else
        be = (p != 0);
        g  = 1'b0;
        gv = (p == 16);
`endif
        return {be, (p >= 32), (p >= 56 && p <= 62), (p == 31), (p == 63),
                ((p % 8) == 7), ((p % 4) == 3), g, gv};
    endfunction

    task automatic check_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pop the oldest expectation and compare with the DUT outputs.
    task automatic sb_check(string name);
        logic [8:0] e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL %s actual=%b required=%b", name, obs, e);
            end
        end
    endtask

    task automatic step_expect(logic [8:0] e, string name);
        sb_q.push_back(e);
        @(posedge sys_clock_i);
        #1;
        sb_check(name);
    endtask

    // One reset edge, then release: the DUT is in phase 0 afterwards.
    task automatic do_reset();
        reset_i = 1'b1;
        step_expect(9'd0, "reset_zero");
        reset_i = 1'b0;
    endtask

    typedef struct {
        int   phase;
        logic phi2, wr, sr1, sr2, c8, c16;
        logic be_m, g_m, gv_m;   // MCU slot build
        logic be_n, gv_n;        // default build (grant always 0)
    } vec_t;

    vec_t tbl[12];
    int   rise1[9], rise2[9], fall1[9];
    int   be_low;
    real  t0, t1, mhz;
    logic [8:0] prev, e;

    initial begin
        //            ph  phi wr sr1 sr2 c8 c16 beM gM gvM beN gvN
        tbl[0]  = '{  0,  0, 0, 0,  0,  0, 0,  0,  0, 0,  0,  0};
        tbl[1]  = '{  1,  0, 0, 0,  0,  0, 0,  0,  1, 1,  1,  0};
        tbl[2]  = '{  3,  0, 0, 0,  0,  0, 1,  0,  1, 0,  1,  0};
        tbl[3]  = '{  7,  0, 0, 0,  0,  1, 1,  0,  1, 0,  1,  0};
        tbl[4]  = '{ 15,  0, 0, 0,  0,  1, 1,  0,  1, 0,  1,  0};
        tbl[5]  = '{ 16,  0, 0, 0,  0,  0, 0,  1,  0, 1,  1,  1};
        tbl[6]  = '{ 31,  0, 0, 1,  0,  1, 1,  1,  0, 0,  1,  0};
        tbl[7]  = '{ 32,  1, 0, 0,  0,  0, 0,  1,  0, 0,  1,  0};
        tbl[8]  = '{ 55,  1, 0, 0,  0,  1, 1,  1,  0, 0,  1,  0};
        tbl[9]  = '{ 56,  1, 1, 0,  0,  0, 0,  1,  0, 0,  1,  0};
        tbl[10] = '{ 62,  1, 1, 0,  0,  0, 0,  1,  0, 0,  1,  0};
        tbl[11] = '{ 63,  1, 0, 0,  1,  1, 1,  1,  0, 0,  1,  0};

        // Reset held across several edges keeps all outputs low.
        reset_i = 1'b1;
        step_expect(9'd0, "reset_hold");
        step_expect(9'd0, "reset_hold");

        // System clock frequency from two posedges.
        @(posedge sys_clock_i);
        t0 = $realtime;
        @(posedge sys_clock_i);
        t1 = $realtime;
        mhz = 1000.0 / (t1 - t0);
        checks++;
        if (mhz < 63.995 || mhz > 64.005) begin
            failures++;
            $display("FAIL sys_clock_mhz actual=%f required=64.00", mhz);
        end
        #1;

        // Phase table: reset, advance to the phase, compare.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            if (tbl[i].phase == 0) begin
                sb_q.push_back(9'd0);
                sb_check("tbl_phase0");
            end else begin
                repeat (tbl[i].phase - 1) @(posedge sys_clock_i);
`ifdef MCU_SLOT_EN
                e = {tbl[i].be_m, tbl[i].phi2, tbl[i].wr, tbl[i].sr1, tbl[i].sr2,
                     tbl[i].c8, tbl[i].c16, tbl[i].g_m, tbl[i].gv_m};
`else
                e = {tbl[i].be_n, tbl[i].phi2, tbl[i].wr, tbl[i].sr1, tbl[i].sr2,
                     tbl[i].c8, tbl[i].c16, 1'b0, tbl[i].gv_n};
`endif
                step_expect(e, $sformatf("tbl_phase%0d", tbl[i].phase));
            end
        end

        // Free run over two periods against the model, recording edges.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            rise1[k] = -1; rise2[k] = -1; fall1[k] = -1;
        end
        be_low = 0;
        prev   = obs;
        for (int c = 1; c <= 130; c++) begin
            step_expect(exp_out(c % 64), $sformatf("freerun_c%0d", c));
            for (int k = 0; k < 9; k++) begin
                if (obs[k] && !prev[k]) begin
                    if (rise1[k] < 0) rise1[k] = c;
                    else if (rise2[k] < 0) rise2[k] = c;
                end
                if (!obs[k] && prev[k] && fall1[k] < 0) fall1[k] = c;
            end
            if (c >= 64 && c < 128 && !obs[8]) be_low++;
            prev = obs;
        end

        check_int("period_cpu_be",    rise2[8] - rise1[8], 64);
        check_int("period_cpu_clock", rise2[7] - rise1[7], 64);
        check_int("period_wr_strobe", rise2[6] - rise1[6], 64);
        check_int("period_load_sr1",  rise2[5] - rise1[5], 64);
        check_int("period_load_sr2",  rise2[4] - rise1[4], 64);
        check_int("period_clk8_en",   rise2[3] - rise1[3], 8);
        check_int("period_clk16_en",  rise2[2] - rise1[2], 4);
        check_int("width_clk8_en",    fall1[3] - rise1[3], 1);
        check_int("width_clk16_en",   fall1[2] - rise1[2], 1);
        check_int("first_cpu_clock_rise", rise1[7], 32);
        check_int("sr1_before_phi2_rise", rise1[7] - rise1[5], 1);
        check_int("wr_fall_before_phi2_fall", fall1[7] - fall1[6], 1);
`ifdef MCU_SLOT_EN
        check_int("cpu_be_low_cycles", be_low, 16);
`else
        check_int("cpu_be_low_cycles", be_low, 1);
`endif

        // Reset at phase 40, then restart from phase 0.
        do_reset();
        repeat (39) @(posedge sys_clock_i);
        step_expect(exp_out(40), "pre_reset_phase40");
        reset_i = 1'b1;
        step_expect(9'd0, "mid_reset_zero");
        reset_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step_expect(exp_out(c), $sformatf("restart_c%0d", c));
            check_int($sformatf("restart_clk16_c%0d", c), int'(clk16_en_o), (c == 3) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
